// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding control for the 5-stage core with multi-cycle execute
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_LATENCY     = 4,
    parameter int MC_CNT_WIDTH   = $clog2(MC_LATENCY + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ValidD_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdD_i,
    input  logic                      RegWriteD_i,
    input  logic                      MemReadD_i,
    input  logic                      MultiCycD_i,
    input  logic                      PCSrcE_i,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic                      StallE_o,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic                      BusyE_o
);

    localparam logic [MC_CNT_WIDTH-1:0] CNT_LOAD = MC_CNT_WIDTH'(MC_LATENCY - 1);

    logic                      e_v, e_rw, e_mr, e_mc;
    logic [REG_ADDR_WIDTH-1:0] e_rs1, e_rs2, e_rd;
    logic                      m_v, m_rw;
    logic [REG_ADDR_WIDTH-1:0] m_rd;
    logic                      w_v, w_rw;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [MC_CNT_WIDTH-1:0]   cnt;

    logic busy, load_use;

    assign busy     = e_v & e_mc & (cnt != '0);
    assign load_use = e_v & e_mr & (e_rd != '0) & ValidD_i &
                      ((e_rd == Rs1D_i) | (e_rd == Rs2D_i));

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_v && (rs != '0)) begin
            if (m_v && m_rw && (m_rd == rs))
                sel = 2'b10;
            else if (w_v && w_rw && (w_rd == rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    // Outputs are forced low while reset is held so a stray PCSrcE_i cannot flush.
    always_comb begin
        StallF_o    = 1'b0;
        StallD_o    = 1'b0;
        FlushD_o    = 1'b0;
        FlushE_o    = 1'b0;
        StallE_o    = 1'b0;
        BusyE_o     = 1'b0;
        ForwardAE_o = 2'b00;
        ForwardBE_o = 2'b00;
        if (rst) begin
            ForwardAE_o = fwd_sel(e_rs1);
            ForwardBE_o = fwd_sel(e_rs2);
            if (busy) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                BusyE_o  = 1'b1;
            end else if (PCSrcE_i) begin
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (load_use) begin
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_v   <= 1'b0;
            e_rw  <= 1'b0;
            e_mr  <= 1'b0;
            e_mc  <= 1'b0;
            e_rs1 <= '0;
            e_rs2 <= '0;
            e_rd  <= '0;
            m_v   <= 1'b0;
            m_rw  <= 1'b0;
            m_rd  <= '0;
            w_v   <= 1'b0;
            w_rw  <= 1'b0;
            w_rd  <= '0;
            cnt   <= '0;
        end else begin
            w_v  <= m_v;
            w_rw <= m_rw;
            w_rd <= m_rd;
            if (busy) begin
                // E holds the multi-cycle op; M receives a bubble each busy cycle.
                m_v <= 1'b0;
                cnt <= cnt - 1'b1;
            end else begin
                m_v  <= e_v;
                m_rw <= e_rw;
                m_rd <= e_rd;
                if (PCSrcE_i || load_use) begin
                    e_v <= 1'b0;
                    cnt <= '0;
                end else begin
                    e_v   <= ValidD_i;
                    e_rw  <= RegWriteD_i;
                    e_mr  <= MemReadD_i;
                    e_mc  <= MultiCycD_i;
                    e_rs1 <= Rs1D_i;
                    e_rs2 <= Rs2D_i;
                    e_rd  <= RdD_i;
                    cnt   <= (ValidD_i && MultiCycD_i) ? CNT_LOAD : '0;
                end
            end
        end
    end

endmodule
